// File: rtl/layer_sequencer_if.sv
// Layer-descriptor / datapath-control bundle between the instruction controller
// (master) and the dense-layer sequencer (slave).
interface layer_sequencer_if #(
  parameter int NU_COUNT     = 4,
  parameter int XY_MEM_DEPTH = 8,
  parameter int W_MEM_DEPTH  = 8,
  parameter int CNT_W        = 8
);
  logic                    start;
  logic [XY_MEM_DEPTH-1:0] x_base;
  logic [W_MEM_DEPTH-1:0]  w_base;
  logic [XY_MEM_DEPTH-1:0] y_base;
  logic [CNT_W-1:0]        in_count;
  logic [CNT_W-1:0]        out_count;
  logic                    busy;
  logic                    done;
  logic [NU_COUNT-1:0]     mac_reg_enable;
  logic                    mac_acc_loopback;
  logic                    serializer_update;
  logic                    act_input_select;
  logic [XY_MEM_DEPTH-1:0] xy_read_addr;
  logic [W_MEM_DEPTH-1:0]  w_read_addr;
  logic [XY_MEM_DEPTH-1:0] xy_write_addr;
  logic                    xy_write_enable;

  modport master (
    output start, x_base, w_base, y_base, in_count, out_count,
    input  busy, done, mac_reg_enable, mac_acc_loopback, serializer_update,
           act_input_select, xy_read_addr, w_read_addr, xy_write_addr, xy_write_enable
  );

  modport slave (
    input  start, x_base, w_base, y_base, in_count, out_count,
    output busy, done, mac_reg_enable, mac_acc_loopback, serializer_update,
           act_input_select, xy_read_addr, w_read_addr, xy_write_addr, xy_write_enable
  );
endinterface

// File: rtl/layer_sequencer.sv
// Dense-layer sequencer: tiles output neurons over NU_COUNT MAC lanes, then drains
// each tile through serializer/activation into xy memory. Optional: LAYER_SEQ_PERF_EN.
module layer_sequencer #(
  parameter int NU_COUNT     = 4,
  parameter int XY_MEM_DEPTH = 8,
  parameter int W_MEM_DEPTH  = 8,
  parameter int CNT_W        = 8,
  parameter int ACT_LATENCY  = 1
) (
  input logic clk,
  input logic reset,
`ifdef LAYER_SEQ_PERF_EN
  output logic [31:0] perf_cycles,
`endif
  layer_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_FLUSH, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t                  r_state;
  logic [XY_MEM_DEPTH-1:0] r_x_base;
  logic [W_MEM_DEPTH-1:0]  r_w_base;
  logic [XY_MEM_DEPTH-1:0] r_y_base;
  logic [CNT_W-1:0]        r_in_count;
  logic [CNT_W-1:0]        r_k;
  logic [CNT_W-1:0]        r_drain;
  logic [CNT_W-1:0]        r_remaining;
  logic [W_MEM_DEPTH-1:0]  r_w_off;
  logic [XY_MEM_DEPTH-1:0] r_y_off;

  logic                    r_busy;
  logic                    r_done;
  logic [NU_COUNT-1:0]     r_mac_en;
  logic                    r_loopback;
  logic                    r_ser_upd;
  logic                    r_act_sel;
  logic [XY_MEM_DEPTH-1:0] r_xy_ra;
  logic [W_MEM_DEPTH-1:0]  r_w_ra;
  logic [XY_MEM_DEPTH-1:0] r_xy_wa;
  logic                    r_xy_we;

  logic [NU_COUNT-1:0]     w_mask;
  logic [CNT_W-1:0]        w_lanes;
  logic [CNT_W-1:0]        w_drain_nxt;
  logic                    w_drain_last;

  // r_remaining is out_count minus the neurons of all earlier tiles
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NU_COUNT; i++) w_mask[i] = (CNT_W'(i) < r_remaining);
  end

  assign w_lanes      = (r_remaining > CNT_W'(NU_COUNT)) ? CNT_W'(NU_COUNT) : r_remaining;
  assign w_drain_nxt  = r_drain + CNT_W'(1);
  assign w_drain_last = (r_drain == w_lanes + CNT_W'(ACT_LATENCY) - CNT_W'(1));

  // Outputs are registered: each transition loads what the next cycle must show
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_drain     <= '0;
      r_remaining <= '0;
      r_w_off     <= '0;
      r_y_off     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mac_en    <= '0;
      r_loopback  <= 1'b0;
      r_ser_upd   <= 1'b0;
      r_act_sel   <= 1'b0;
      r_xy_ra     <= '0;
      r_w_ra      <= '0;
      r_xy_wa     <= '0;
      r_xy_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x_base    <= bus.x_base;
            r_w_base    <= bus.w_base;
            r_y_base    <= bus.y_base;
            r_in_count  <= bus.in_count;
            r_remaining <= bus.out_count;
            r_w_off     <= '0;
            r_y_off     <= '0;
            r_k         <= '0;
            if (bus.in_count == '0 || bus.out_count == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_xy_ra <= bus.x_base;
              r_w_ra  <= bus.w_base;
              r_state <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          r_mac_en   <= w_mask;
          r_loopback <= (r_k != '0);
          if (r_k == r_in_count - CNT_W'(1)) begin
            r_state <= S_FLUSH;
          end else begin
            r_k     <= r_k + CNT_W'(1);
            r_xy_ra <= r_xy_ra + XY_MEM_DEPTH'(1);
            r_w_ra  <= r_w_ra + W_MEM_DEPTH'(1);
          end
        end
        S_FLUSH: begin
          r_mac_en   <= '0;
          r_loopback <= 1'b0;
          r_ser_upd  <= 1'b1;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          r_ser_upd <= 1'b0;
          r_act_sel <= 1'b1;
          r_drain   <= '0;
          r_state   <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_drain_last) begin
            r_act_sel <= 1'b0;
            r_xy_we   <= 1'b0;
            if (r_remaining > CNT_W'(NU_COUNT)) begin
              // running tile*in_count avoids a multiplier
              r_remaining <= r_remaining - CNT_W'(NU_COUNT);
              r_w_off     <= r_w_off + W_MEM_DEPTH'(r_in_count);
              r_y_off     <= r_y_off + XY_MEM_DEPTH'(NU_COUNT);
              r_k         <= '0;
              r_xy_ra     <= r_x_base;
              r_w_ra      <= r_w_base + r_w_off + W_MEM_DEPTH'(r_in_count);
              r_state     <= S_ACCUM;
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end else begin
            r_drain <= w_drain_nxt;
            r_xy_we <= (w_drain_nxt >= CNT_W'(ACT_LATENCY));
            r_xy_wa <= r_y_base + r_y_off + XY_MEM_DEPTH'(w_drain_nxt - CNT_W'(ACT_LATENCY));
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy              = r_busy;
  assign bus.done              = r_done;
  assign bus.mac_reg_enable    = r_mac_en;
  assign bus.mac_acc_loopback  = r_loopback;
  assign bus.serializer_update = r_ser_upd;
  assign bus.act_input_select  = r_act_sel;
  assign bus.xy_read_addr      = r_xy_ra;
  assign bus.w_read_addr       = r_w_ra;
  assign bus.xy_write_addr     = r_xy_wa;
  assign bus.xy_write_enable   = r_xy_we;

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_perf <= '0;
    end else if (r_busy && r_perf != '1) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: cycle-level expected trace built from the layer rules,
// checked every cycle, plus literal pins on the documented scenarios.
module tb_layer_sequencer;
  localparam int NU   = 4;
  localparam int XYW  = 8;
  localparam int WW   = 8;
  localparam int CW   = 8;
  localparam int ACT  = 1;
  localparam int MAXC = 64;

  logic clk = 1'b0;
  logic reset;

  layer_sequencer_if #(.NU_COUNT(NU), .XY_MEM_DEPTH(XYW), .W_MEM_DEPTH(WW), .CNT_W(CW)) bus ();
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  layer_sequencer #(
    .NU_COUNT(NU), .XY_MEM_DEPTH(XYW), .W_MEM_DEPTH(WW), .CNT_W(CW), .ACT_LATENCY(ACT)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef LAYER_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_busy[MAXC], exp_done[MAXC], exp_mac[MAXC], exp_lb[MAXC], exp_ser[MAXC];
  int exp_act[MAXC], exp_ra[MAXC], exp_xra[MAXC], exp_wra[MAXC], exp_we[MAXC], exp_wa[MAXC];
  int cap_xra[MAXC], cap_wra[MAXC], cap_mac[MAXC], cap_lb[MAXC], cap_ser[MAXC];
  int cap_we[MAXC], cap_wa[MAXC], cap_done[MAXC];
  int last = 0;
  int start_cyc = 0;
  int rel_c = 0;
  bit chk_en = 1'b0;
  bit rst_chk = 1'b0;

  function automatic void chk(input string nm, input int idx, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, idx, got, want);
    end
  endfunction

  task automatic build_model(input int x, input int w, input int y, input int ni, input int no);
    int t, lanes, mask, d0;
    for (int i = 0; i < MAXC; i++) begin
      exp_busy[i] = 0; exp_done[i] = 0; exp_mac[i] = 0; exp_lb[i] = 0; exp_ser[i] = 0;
      exp_act[i] = 0; exp_ra[i] = 0; exp_xra[i] = 0; exp_wra[i] = 0; exp_we[i] = 0; exp_wa[i] = 0;
    end
    if (ni == 0 || no == 0) begin
      exp_done[1] = 1;
      last = 1;
      return;
    end
    t = 1;
    for (int tile = 0; tile * NU < no; tile++) begin
      lanes = (no - tile * NU < NU) ? (no - tile * NU) : NU;
      mask  = (1 << lanes) - 1;
      for (int k = 0; k < ni; k++) begin
        exp_busy[t+k] = 1;
        exp_ra[t+k]   = 1;
        exp_xra[t+k]  = (x + k) % 256;
        exp_wra[t+k]  = (w + tile * ni + k) % 256;
        exp_mac[t+k+1] = mask;
        exp_lb[t+k+1]  = (k != 0) ? 1 : 0;
      end
      exp_busy[t+ni] = 1;
      exp_ra[t+ni]   = 1;
      exp_xra[t+ni]  = (x + ni - 1) % 256;
      exp_wra[t+ni]  = (w + tile * ni + ni - 1) % 256;
      exp_busy[t+ni+1] = 1;
      exp_ser[t+ni+1]  = 1;
      d0 = t + ni + 2;
      for (int c = 0; c < lanes + ACT; c++) begin
        exp_busy[d0+c] = 1;
        exp_act[d0+c]  = 1;
      end
      for (int j = 0; j < lanes; j++) begin
        exp_we[d0+j+ACT] = 1;
        exp_wa[d0+j+ACT] = (y + tile * NU + j) % 256;
      end
      t = d0 + lanes + ACT;
    end
    exp_done[t] = 1;
    last = t;
  endtask

  // Single compare process: reset-zero checks and per-cycle model checks
  always @(negedge clk) begin
    if (rst_chk) begin
      chk("rst_busy", cyc, int'(bus.busy), 0);
      chk("rst_done", cyc, int'(bus.done), 0);
      chk("rst_mac", cyc, int'(bus.mac_reg_enable), 0);
      chk("rst_lb", cyc, int'(bus.mac_acc_loopback), 0);
      chk("rst_ser", cyc, int'(bus.serializer_update), 0);
      chk("rst_act", cyc, int'(bus.act_input_select), 0);
      chk("rst_xra", cyc, int'(bus.xy_read_addr), 0);
      chk("rst_wra", cyc, int'(bus.w_read_addr), 0);
      chk("rst_wa", cyc, int'(bus.xy_write_addr), 0);
      chk("rst_we", cyc, int'(bus.xy_write_enable), 0);
    end
    if (chk_en) begin
      rel_c = cyc - start_cyc;
      if (rel_c >= 0 && rel_c < MAXC && rel_c <= last + 2) begin
        cap_xra[rel_c]  = int'(bus.xy_read_addr);
        cap_wra[rel_c]  = int'(bus.w_read_addr);
        cap_mac[rel_c]  = int'(bus.mac_reg_enable);
        cap_lb[rel_c]   = int'(bus.mac_acc_loopback);
        cap_ser[rel_c]  = int'(bus.serializer_update);
        cap_we[rel_c]   = int'(bus.xy_write_enable);
        cap_wa[rel_c]   = int'(bus.xy_write_addr);
        cap_done[rel_c] = int'(bus.done);
        chk("busy", rel_c, int'(bus.busy), exp_busy[rel_c]);
        chk("done", rel_c, int'(bus.done), exp_done[rel_c]);
        chk("mac_en", rel_c, int'(bus.mac_reg_enable), exp_mac[rel_c]);
        chk("ser_upd", rel_c, int'(bus.serializer_update), exp_ser[rel_c]);
        chk("act_sel", rel_c, int'(bus.act_input_select), exp_act[rel_c]);
        chk("wr_en", rel_c, int'(bus.xy_write_enable), exp_we[rel_c]);
        if (exp_mac[rel_c] != 0) chk("loopback", rel_c, int'(bus.mac_acc_loopback), exp_lb[rel_c]);
        if (exp_ra[rel_c] != 0) begin
          chk("xy_raddr", rel_c, int'(bus.xy_read_addr), exp_xra[rel_c]);
          chk("w_raddr", rel_c, int'(bus.w_read_addr), exp_wra[rel_c]);
        end
        if (exp_we[rel_c] != 0) chk("xy_waddr", rel_c, int'(bus.xy_write_addr), exp_wa[rel_c]);
      end
    end
  end

  task automatic do_op(input int x, input int w, input int y, input int ni, input int no,
                       input int ign_at);
    build_model(x, w, y, ni, no);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x_base = XYW'(x); bus.w_base = WW'(w); bus.y_base = XYW'(y);
    bus.in_count = CW'(ni); bus.out_count = CW'(no);
    start_cyc = cyc;
    chk_en = 1'b1;
    for (int i = 1; i <= last + 2; i++) begin
      @(posedge clk); #1;
      bus.start = (i == ign_at);
      if (i == ign_at) begin
        bus.x_base = 8'd100; bus.y_base = 8'd200; bus.in_count = 8'd1; bus.out_count = 8'd1;
      end
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic reset_seq();
    reset = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    rst_chk = 1'b0;
  endtask

  int sum;

  initial begin
    bus.start = 1'b0; bus.x_base = '0; bus.w_base = '0; bus.y_base = '0;
    bus.in_count = '0; bus.out_count = '0;
    reset_seq();

    // Single tile
    do_op(0, 0, 16, 3, 4, -1);
    for (int i = 1; i <= 3; i++) begin
      chk("lit_xra", i, cap_xra[i], i - 1);
      chk("lit_wra", i, cap_wra[i], i - 1);
    end
    for (int i = 2; i <= 4; i++) begin
      chk("lit_mac", i, cap_mac[i], 15);
      chk("lit_lb", i, cap_lb[i], (i == 2) ? 0 : 1);
    end
    chk("lit_ser", 5, cap_ser[5], 1);
    for (int i = 7; i <= 10; i++) begin
      chk("lit_we", i, cap_we[i], 1);
      chk("lit_wa", i, cap_wa[i], 16 + i - 7);
    end
    chk("lit_done", 11, cap_done[11], 1);
`ifdef LAYER_SEQ_PERF_EN
    chk("perf", cyc, int'(perf_cycles), 10);
    repeat (3) @(posedge clk);
    #1 chk("perf_hold", cyc, int'(perf_cycles), 10);
`endif

    // Two tiles
    do_op(0, 8, 32, 2, 6, -1);
    chk("lit2_wra", 1, cap_wra[1], 8);
    chk("lit2_wra", 2, cap_wra[2], 9);
    chk("lit2_wa", 6, cap_wa[6], 32);
    chk("lit2_wa", 9, cap_wa[9], 35);
    chk("lit2_wra", 10, cap_wra[10], 10);
    chk("lit2_wra", 11, cap_wra[11], 11);
    chk("lit2_mac", 12, cap_mac[12], 3);
    chk("lit2_wa", 15, cap_wa[15], 36);
    chk("lit2_wa", 16, cap_wa[16], 37);
    sum = 0;
    for (int i = 0; i <= 19; i++) sum += cap_done[i];
    chk("lit2_done_pulses", 19, sum, 1);

    // Zero count
    do_op(0, 0, 0, 0, 5, -1);
    chk("lit0_done", 1, cap_done[1], 1);
    sum = 0;
    for (int i = 0; i <= 3; i++) sum += cap_we[i] + cap_mac[i];
    chk("lit0_no_activity", 3, sum, 0);

    // Address wrap plus an ignored start during ACCUM
    do_op(5, 0, 254, 3, 4, 2);
    chk("litw_wa", 7, cap_wa[7], 254);
    chk("litw_wa", 8, cap_wa[8], 255);
    chk("litw_wa", 9, cap_wa[9], 0);
    chk("litw_wa", 10, cap_wa[10], 1);
    sum = 0;
    for (int i = 0; i <= 13; i++) sum += cap_done[i];
    chk("litw_done_pulses", 13, sum, 1);

    // Reset while in ACCUM
    @(posedge clk); #1;
    bus.start = 1'b1; bus.x_base = 8'd0; bus.w_base = 8'd0; bus.y_base = 8'd0;
    bus.in_count = 8'd10; bus.out_count = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("midop_busy", cyc, int'(bus.busy), 1);
    chk("midop_mac", cyc, int'(bus.mac_reg_enable), 15);
    reset_seq();
    repeat (2) @(posedge clk);
    #1 chk("post_rst_idle_busy", cyc, int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Sequences one dense layer on the shared MAC/serializer/activation datapath. It drives the xy and w memory read addresses, the per-lane MAC enables, the serializer load and the xy write-back. Output neurons are processed in tiles of NU_COUNT lanes. It sits beside the instruction controller, which starts it with a layer descriptor and waits for done.

Parameters:
NU_COUNT, 4, number of MAC lanes (neurons per tile)
XY_MEM_DEPTH, 8, xy memory address width in bits
W_MEM_DEPTH, 8, w memory address width in bits
CNT_W, 8, width of in_count and out_count
ACT_LATENCY, 1, activation function latency in cycles (allowed range 1..3)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
x_base  input  XY_MEM_DEPTH  first input-vector address
w_base  input  W_MEM_DEPTH  first weight address (same in every lane memory)
y_base  input  XY_MEM_DEPTH  first output address
in_count  input  CNT_W  inputs per neuron
out_count  input  CNT_W  neurons in the layer
busy  output  1  high from the cycle after start is accepted until the end of the last DRAIN
done  output  1  one-cycle completion pulse
mac_reg_enable  output  NU_COUNT  per-lane MAC register enable
mac_acc_loopback  output  1  0 = load product, 1 = accumulate
serializer_update  output  1  load pulse for the serializer
act_input_select  output  1  1 = activation input taken from serializer
xy_read_addr  output  XY_MEM_DEPTH  x read address
w_read_addr  output  W_MEM_DEPTH  weight read address
xy_write_addr  output  XY_MEM_DEPTH  y write address
xy_write_enable  output  1  y write strobe

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation: next cycle is IDLE with all outputs 0; pending writes are discarded.
- Memory and activation latencies: memory read latency is 1 cycle; activation latency is ACT_LATENCY.
- Serializer: presents lane j on serial_out j+1 cycles after its load cycle.
- States: IDLE -> ACCUM -> FLUSH -> LOAD -> DRAIN -> (ACCUM for the next tile | DONE) -> IDLE.
- IDLE:
  - start=1 latches all config; tile=0.
  - If in_count==0 or out_count==0, go directly to DONE (no reads, no writes).
  - Otherwise go to ACCUM.
  - start while not in IDLE is ignored.
- ACCUM (in_count cycles, k=0..in_count-1):
  - xy_read_addr = x_base+k.
  - w_read_addr = w_base+tile*in_count+k.
  - mac_reg_enable = lane mask, registered one cycle after address k.
  - mac_acc_loopback = 0 for the enable slot of k=0, otherwise 1.
- Lane mask: lane i set iff tile*NU_COUNT+i < out_count.
- FLUSH (1 cycle): final enable slot for k=in_count-1; addresses hold.
- LOAD (1 cycle): serializer_update=1; mac_reg_enable=0.
- DRAIN (lanes+ACT_LATENCY cycles, lanes = popcount of the mask):
  - act_input_select=1 throughout.
  - In DRAIN cycle j+ACT_LATENCY: xy_write_enable=1, xy_write_addr=y_base+tile*NU_COUNT+j, for j=0..lanes-1.
- After DRAIN: if further neurons remain, tile+1 and go to ACCUM; else DONE.
- DONE (1 cycle): done=1, busy=0; then IDLE. A start in DONE is ignored.
- Arithmetic: all address sums are modulo 2^width (wrap, no error). The tile*in_count product is computed in a running W_MEM_DEPTH accumulator, not a multiplier.
- Overlapping x and y regions are not checked.

Optional Feature:
- Macro: LAYER_SEQ_PERF_EN.
- Defined: adds output perf_cycles (32 bits).
  - Cleared to 0 when start is accepted.
  - Increments every cycle busy=1.
  - Holds its value after done; reset to 0; saturates at all-ones.
- Undefined: perf_cycles is absent; no counter logic.

Test Plan:
- Reset: hold reset 3 cycles, including after a forced mid-ACCUM state -> every output 0, busy=0, done=0.
- Single tile (NU_COUNT=4, ACT_LATENCY=1), x_base=0, w_base=0, y_base=16, in=3, out=4, start at cycle 0:
  - xy/w_read_addr 0,1,2 in cycles 1-3.
  - mac_reg_enable=4'b1111 in cycles 2-4, with mac_acc_loopback 0,1,1.
  - serializer_update in cycle 5.
  - Writes to addresses 16,17,18,19 in cycles 7-10.
  - done=1 in cycle 11.
- Two tiles, in=2, out=6, w_base=8, y_base=32:
  - Tile 0: w_read_addr 8,9, mask 4'b1111, writes 32-35.
  - Tile 1: w_read_addr 10,11, mask 4'b0011, writes 36,37 only.
  - Exactly one done pulse.
- Zero count: start with in=0, out=5 -> done in cycle 1, no xy_write_enable, no mac_reg_enable.
- Wrap and ignored start: y_base=254, out=4 (XY_MEM_DEPTH=8) -> writes to 254,255,0,1. A second start issued during ACCUM is ignored, with no extra done pulse.
- Perf counter (LAYER_SEQ_PERF_EN defined), single-tile case above -> perf_cycles=10 after done, held until the next start.
